vga_scan_driver: RTL and testbench
==================================

// Module: vga_scan_driver
// PURPOSE
//  Producer end of the DrawX/DrawY -> Red/Green/Blue pixel interface.
//  Free-running H/V counters drive DrawX/DrawY into color_mapper. The block
//  takes color_mapper's combinational RGB back and registers it with sync and
//  blank onto the VGA pins, all aligned in one pipeline stage.
//  Also provides frame_clk (= VGA_VS), which clocks fruit motion.
// PARAMETERS
//  H_VISIBLE 640  active pixels per line
//  H_FP      16   horizontal front porch, in pixels
//  H_SYNC    96   horizontal sync width, in pixels
//  H_BP      48   horizontal back porch; H_TOTAL = sum of the four = 800
//  V_VISIBLE 480  active lines per frame
//  V_FP      10   vertical front porch, in lines
//  V_SYNC    2    vertical sync width, in lines
//  V_BP      33   vertical back porch; V_TOTAL = sum of the four = 525
// PORTS
//  VGA_Clk     in   1   pixel clock (25 MHz)
//  Reset_n     in   1   asynchronous, active-low reset
//  Red         in   8   pixel colour for the current DrawX/DrawY (comb. from color_mapper)
//  Green       in   8   "
//  Blue        in   8   "
//  DrawX       out  10  current h count, 0..H_TOTAL-1 (combinational from the register)
//  DrawY       out  10  current v count, 0..V_TOTAL-1
//  frame_start out  1   high for the single cycle where DrawX==0 && DrawY==0
//  frame_clk   out  1   equals VGA_VS
//  blank       out  1   registered; 1 = visible pixel, 0 = blanking
//  VGA_HS      out  1   registered, active-low horizontal sync
//  VGA_VS      out  1   registered, active-low vertical sync
//  VGA_R/G/B   out  8 each  registered pixel colour
// BEHAVIOUR
//  Counters:
//   - h_cnt increments every clock. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
//   - v_cnt wraps to 0 when h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1 (both wrap same edge).
//   - DrawX = h_cnt and DrawY = v_cnt. Counters are never clamped at the visible edge.
//  Per-cycle decode, from the counters in cycle n:
//   - vis = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE)
//   - hs_n = 0 iff H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC   (656..751)
//   - vs_n = 0 iff V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC   (490..491)
//  Output stage, latency 1:
//   - At edge n+1: blank <= vis; VGA_HS <= hs_n; VGA_VS <= vs_n.
//   - VGA_R/G/B <= vis ? Red/Green/Blue : 0. Blanking always drives black,
//     whatever the input.
//   - Sync, blank and colour therefore always describe the same pixel.
//  frame_start is decoded combinationally from the counters, the same cycle as DrawX/DrawY.
//  Reset (async assert, sync release):
//   - h_cnt=0, v_cnt=0, DrawX=0, DrawY=0, frame_start=1.
//   - blank=0, VGA_HS=1, VGA_VS=1, frame_clk=1, VGA_R/G/B=0.
//  First edge after release:
//   - h_cnt=1; outputs show pixel (0,0) with blank=1.
//  Reset mid-frame: everything returns to the values above at once. There is no
//  partial-line flush; the frame restarts at (0,0).
//  No handshake: the Red/Green/Blue inputs are sampled every cycle and
//  color_mapper must settle within one VGA_Clk period.
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined:
//   - Adds input test_mode (1 bit).
//   - When test_mode=1, the RGB sampled into the output stage is 8 vertical
//     colour bars of 80 px each, selected by h_cnt[9:7] ^ (h_cnt>=...)—no:
//     bar index = h_cnt / 80.
//   - Bar colours: R = {8{idx[2]}}, G = {8{idx[1]}}, B = {8{idx[0]}}.
//   - Red/Green/Blue are ignored while test_mode=1.
//   - Blanking still forces 0 and all timing is unchanged.
//  VGA_TEST_PATTERN_EN undefined: no test_mode port; the output always
//  passes Red/Green/Blue.
// TESTING
//  T1 reset: Reset_n=0 mid-line ->
//   - at once: DrawX=0, DrawY=0, VGA_HS=1, VGA_VS=1, RGB=0, blank=0.
//   - after release, first edge: blank=1.
//  T2 line timing: run one line ->
//   - VGA_HS low for exactly 96 clocks; falling edge 657 clocks after DrawX=0 is presented.
//   - blank high for 640 clocks.
//  T3 frame timing: run 800*525 = 420000 clocks ->
//   - one frame_start pulse.
//   - VGA_VS low for 1600 clocks, starting one cycle after DrawY becomes 490.
//   - DrawY wraps from 524 to 0 on the same edge DrawX wraps from 799 to 0.
//  T4 colour path:
//   - Red = DrawX[7:0] -> VGA_R at edge n+1 equals the DrawX value of cycle n,
//     for DrawX 0..639.
//   - VGA_R = 0 for DrawX 640..799, including when Red = 8'hFF.
//  T5 blanking lines: Red/Green/Blue = 8'hFF held ->
//   - RGB = 0 and blank = 0 for the whole of every line with DrawY 480..524.
//  T6 macro build (VGA_TEST_PATTERN_EN), test_mode=1 ->
//   - DrawX=0: RGB = 000000.
//   - DrawX=80: RGB = 0000FF.
//   - DrawX=560: RGB = FFFFFF.

Source files
------------

// File: rtl/vga_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vga_scan_driver                                                  |
// | Brief   : Free-running VGA H/V scan counters feeding DrawX/DrawY to the    |
// |           colour mapper, with a one-stage output register that aligns      |
// |           sync, blank and the returned RGB onto the VGA pins.              |
// | Option  : VGA_TEST_PATTERN_EN adds test_mode and 8 vertical colour bars.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module vga_scan_driver #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       VGA_Clk,
  input  logic       Reset_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic       frame_clk,
  output logic       blank,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int         C_H_TOTAL    = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int         C_V_TOTAL    = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] C_H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] C_H_SYNC_ON  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] C_H_SYNC_OFF = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] C_H_LAST     = 10'(C_H_TOTAL - 1);
  localparam logic [9:0] C_V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] C_V_SYNC_ON  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] C_V_SYNC_OFF = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] C_V_LAST     = 10'(C_V_TOTAL - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       vis, hs_n, vs_n;
  logic [7:0] pix_r, pix_g, pix_b;
  logic       blank_q, hs_q, vs_q;
  logic [7:0] r_q, g_q, b_q;

  // Next scan position: h wraps every line, v advances only on the h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == C_H_LAST) begin
      h_cnt_d = 10'd0;
      v_cnt_d = (v_cnt_q == C_V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end
  end

  // Scan position registers; reset restarts the frame at (0,0) immediately.
  always_ff @(posedge VGA_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar_idx;

  // Bar index = h / (H_VISIBLE/8), built from threshold compares instead of a divider.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt_q >= 10'(k * (H_VISIBLE / 8))) bar_idx = 3'(k);
    end
  end
`endif

  // Decode timing for the current pixel and pick the colour source.
  always_comb begin
    vis   = (h_cnt_q < C_H_VIS) && (v_cnt_q < C_V_VIS);
    hs_n  = !((h_cnt_q >= C_H_SYNC_ON) && (h_cnt_q < C_H_SYNC_OFF));
    vs_n  = !((v_cnt_q >= C_V_SYNC_ON) && (v_cnt_q < C_V_SYNC_OFF));
    pix_r = Red;
    pix_g = Green;
    pix_b = Blue;
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode) begin
      pix_r = {8{bar_idx[2]}};
      pix_g = {8{bar_idx[1]}};
      pix_b = {8{bar_idx[0]}};
    end
`endif
  end

  // Output stage: sync, blank and colour of one pixel land together, black when not visible.
  always_ff @(posedge VGA_Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      r_q     <= 8'h00;
      g_q     <= 8'h00;
      b_q     <= 8'h00;
    end else begin
      blank_q <= vis;
      hs_q    <= hs_n;
      vs_q    <= vs_n;
      r_q     <= vis ? pix_r : 8'h00;
      g_q     <= vis ? pix_g : 8'h00;
      b_q     <= vis ? pix_b : 8'h00;
    end
  end

  assign DrawX       = h_cnt_q;
  assign DrawY       = v_cnt_q;
  assign frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  assign frame_clk   = vs_q;
  assign blank       = blank_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_vga_scan_driver                                               |
// | Brief   : Scoreboard bench for vga_scan_driver. Horizontal timing is the   |
// |           standard 800-pixel line; the vertical geometry is shortened so   |
// |           whole frames fit in a short run (sync width stays 2 lines).      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_vga_scan_driver;

  localparam int HV = 640, HFP = 16, HSW = 96, HBP = 48;
  localparam int HT = HV + HFP + HSW + HBP;
  localparam int VV = 6, VFP = 2, VSW = 2, VBP = 3;
  localparam int VT = VV + VFP + VSW + VBP;

  logic       VGA_Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] Red = 8'h00, Green = 8'h00, Blue = 8'h00;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_mode = 1'b0;
`endif
  logic [9:0] DrawX, DrawY;
  logic       frame_start, frame_clk, blank, VGA_HS, VGA_VS;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  vga_scan_driver #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) u_dut (
    .VGA_Clk    (VGA_Clk),
    .Reset_n    (Reset_n),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode  (test_mode),
`endif
    .Red        (Red),
    .Green      (Green),
    .Blue       (Blue),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .frame_start(frame_start),
    .frame_clk  (frame_clk),
    .blank      (blank),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B)
  );

  always #20 VGA_Clk = ~VGA_Clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [26:0] sb_q[$];
  int          mh, mv;
  int          edges = 0;
  int          x0_edge, y0_edge;
  int          hs_low, blank_hi, vs_low, fs_cnt;
  int          prev_x, prev_y;
  logic        prev_hs, prev_vs;
  int          mode = 0;
  bit          tm = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference output for a pixel: {blank, hs, vs, R, G, B}
  function automatic logic [26:0] model_out(input int h, input int v,
                                            input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b, input bit t);
    logic       vis, hs, vs;
    logic [7:0] orr, og, ob;
    int         idx;
    vis = (h < HV) && (v < VV);
    hs  = !((h >= HV + HFP) && (h < HV + HFP + HSW));
    vs  = !((v >= VV + VFP) && (v < VV + VFP + VSW));
    orr = r; og = g; ob = b;
    if (t) begin
      idx = h / 80;
      orr = idx[2] ? 8'hFF : 8'h00;
      og  = idx[1] ? 8'hFF : 8'h00;
      ob  = idx[0] ? 8'hFF : 8'h00;
    end
    if (!vis) begin orr = 8'h00; og = 8'h00; ob = 8'h00; end
    return {vis, hs, vs, orr, og, ob};
  endfunction

  task automatic clear_stats();
    hs_low = 0; blank_hi = 0; vs_low = 0; fs_cnt = 0;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_x = 0; prev_y = 0;
    x0_edge = 0; y0_edge = 0;
  endtask

  // Starts and ends at a falling edge: drive, push, clock, pop and compare.
  task automatic step();
    logic [26:0] e, got;
    int ph, pv;
    check_val("drawx", DrawX, mh);
    check_val("drawy", DrawY, mv);
    check_val("frame_start", frame_start, (mh == 0 && mv == 0) ? 1 : 0);
    if (prev_x == HT - 1 && prev_y == VT - 1)
      check_val("wrap_xy", {DrawX, DrawY}, 20'd0);
    prev_x = DrawX; prev_y = DrawY;
    if (frame_start) fs_cnt++;
    if (DrawX == 0) x0_edge = edges;
    if (DrawX == 0 && DrawY == VV + VFP) y0_edge = edges;
    case (mode)
      0: begin Red = DrawX[7:0]; Green = ~DrawX[7:0]; Blue = DrawY[7:0] ^ 8'h5A; end
      1: begin Red = 8'hFF; Green = 8'hFF; Blue = 8'hFF; end
      default: begin Red = 8'($urandom); Green = 8'($urandom); Blue = 8'($urandom); end
    endcase
    sb_q.push_back(model_out(mh, mv, Red, Green, Blue, tm));
    ph = mh; pv = mv;
    @(posedge VGA_Clk);
    edges++;
    #1;
    got = {blank, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B};
    if (sb_q.size() == 0) check_val("sb_empty", 0, 1);
    else begin
      e = sb_q.pop_front();
      check_val("pixel_out", got, e);
      check_val("frame_clk", frame_clk, e[24]);
    end
    if (!VGA_HS) hs_low++;
    if (blank) blank_hi++;
    if (!VGA_VS) vs_low++;
    if (prev_hs && !VGA_HS) check_val("hs_fall_delay", edges - x0_edge, HV + HFP + 1);
    if (prev_vs && !VGA_VS) check_val("vs_fall_delay", edges - y0_edge, 1);
    prev_hs = VGA_HS; prev_vs = VGA_VS;
    if (ph == HT - 1) begin
      check_val("hs_width", hs_low, HSW);
      check_val("blank_width", blank_hi, (pv < VV) ? HV : 0);
      hs_low = 0; blank_hi = 0;
      if (pv == VT - 1) begin
        check_val("vs_width", vs_low, VSW * HT);
        check_val("frame_starts", fs_cnt, 1);
        vs_low = 0; fs_cnt = 0;
      end
    end
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
    @(negedge VGA_Clk);
  endtask

  // Asserts reset between edges, checks the immediate and held values, releases on a falling edge.
  task automatic do_reset();
    @(negedge VGA_Clk);
    Reset_n = 1'b0;
    #1;
    check_val("rst_drawx", DrawX, 0);
    check_val("rst_drawy", DrawY, 0);
    check_val("rst_frame_start", frame_start, 1);
    check_val("rst_outputs", {blank, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}, {1'b0, 1'b1, 1'b1, 24'h0});
    check_val("rst_frame_clk", frame_clk, 1);
    repeat (2) @(posedge VGA_Clk);
    #1;
    check_val("rst_hold_drawx", DrawX, 0);
    check_val("rst_hold_outputs", {blank, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}, {1'b0, 1'b1, 1'b1, 24'h0});
    sb_q.delete();
    mh = 0; mv = 0;
    clear_stats();
    @(negedge VGA_Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    // Power-up reset, then one full frame with a DrawX-derived colour ramp.
    mode = 0;
    do_reset();
    step();
    check_val("first_blank", blank, 1);
    check_val("first_drawx", DrawX, 1);
    repeat (VT * HT - 1) step();

    // Saturated inputs: blanking columns and lines must still read black.
    mode = 1;
    repeat (VT * HT) step();

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars ignore the inputs entirely.
    mode = 2;
    tm = 1'b1; test_mode = 1'b1;
    repeat (HT) step();
    tm = 1'b0; test_mode = 1'b0;
`endif

    // Reset in the middle of a line restarts the frame at (0,0).
    mode = 2;
    repeat (300) step();
    do_reset();
    step();
    check_val("first_blank_mid", blank, 1);
    repeat (HT) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #(40 * 60000);
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
`default_nettype wire
